// File: rtl/apb_pkg.sv
// Shared types and constants for the parametrised APB master bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } state_e;

  localparam logic [1:0] RSP_OK      = 2'd0;
  localparam logic [1:0] RSP_SLVERR  = 2'd1;
  localparam logic [1:0] RSP_DECERR  = 2'd2;
  localparam logic [1:0] RSP_TIMEOUT = 2'd3;

  // Width of the slave-select field; a single slave still needs one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational slave decoder: extracts the select field and flags out-of-range indices.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SEL_LSB = 12,
  localparam int unsigned SelW   = sel_w(NUM_SLV)
) (
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [SelW-1:0]    idx_o,
  output logic [NUM_SLV-1:0] sel_o,
  output logic               valid_o
);

  // Only the select field matters; fold the rest so it is not reported as unused.
  logic unused_addr;
  assign unused_addr = ^addr_i;

  assign idx_o   = addr_i[SEL_LSB +: SelW];
  assign valid_o = (32'(idx_o) < NUM_SLV);

  always_comb begin
    sel_o = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      sel_o[i] = valid_o && (idx_o == SelW'(i));
    end
  end

endmodule

// File: rtl/apb_bridge_n.sv
// APB master bridge: one request at a time, SETUP/ACCESS sequencing to NUM_SLV slaves,
// single-cycle response carrying read data, slave error, decode error or timeout.
module apb_bridge_n
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SEL_LSB = 12,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [1:0]                rsp_code,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int unsigned SelW = sel_w(NUM_SLV);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [SelW-1:0]     idx_q, idx_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_code_q, rsp_code_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;

  logic [SelW-1:0]     dec_idx;
  logic [NUM_SLV-1:0]  dec_sel;
  logic                dec_valid;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_ready;
  logic                sel_err;

  apb_addr_decoder #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV),
    .SEL_LSB (SEL_LSB)
  ) u_dec (
    .addr_i  (req_addr),
    .idx_o   (dec_idx),
    .sel_o   (dec_sel),
    .valid_o (dec_valid)
  );

  // psel_q is one-hot during a transfer, so masking picks the active slave's handshake.
  assign sel_ready = |(PREADY & psel_q);
  assign sel_err   = |(PSLVERR & psel_q);

  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (idx_q == SelW'(i)) sel_rdata = PRDATA[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_code_d  = RSP_OK;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          if (dec_valid) begin
            idx_d       = dec_idx;
            psel_d      = dec_sel;
            req_ready_d = 1'b0;
            state_d     = StSetup;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_code_d  = RSP_DECERR;
          end
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = StAccess;
      end
      StAccess: begin
        if (sel_ready || (cnt_q == CntW'(TIMEOUT - 1))) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = StIdle;
          if (!sel_ready) begin
            rsp_code_d = RSP_TIMEOUT;
          end else if (sel_err) begin
            rsp_code_d = RSP_SLVERR;
          end else if (!pwrite_q) begin
            rsp_rdata_d = sel_rdata;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    rsp_err_d = (rsp_code_d != RSP_OK);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_code_q  <= RSP_OK;
      rsp_err_q   <= 1'b0;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_code_q  <= rsp_code_d;
      rsp_err_q   <= rsp_err_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_code  = rsp_code_q;
  assign rsp_err   = rsp_err_q;
  assign PADDR     = paddr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;

endmodule
